telemetry_frame_tx: RTL and testbench

- Downstream consumer of the PID telemetry FIFOs: pops one wide record per frame (e.g. the concatenated left/right tachometer words) and serializes it into a framed byte stream for uart_tx.
- Frame format:
  - two sync bytes
  - 8-bit sequence number
  - payload bytes, MSB first
  - 8-bit check byte
- Lets the host resynchronize, detect dropped frames and reject corrupted ones.

---
 rtl/telemetry_frame_tx.sv | 151 +++++++++++++++
 tb/tb_telemetry_frame_tx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_frame_tx.sv
// Pops one FIFO record per frame and streams sync, sequence, payload and check bytes to uart_tx.
// Build option: define TELEM_CRC8_EN for a CRC-8 (poly 0x07) check byte instead of the XOR check byte.
module telemetry_frame_tx #(
    parameter int          PAYLOAD_WIDTH = 192,
    parameter logic [7:0]  SYNC_BYTE0    = 8'hA5,
    parameter logic [7:0]  SYNC_BYTE1    = 8'h5A
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fsm_en,
    input  logic [PAYLOAD_WIDTH-1:0] fifo_rd_data,
    input  logic                     fifo_empty,
    output logic                     fifo_rd_en,
    output logic                     uart_start_tx,
    output logic [7:0]               uart_tx_din,
    input  logic                     uart_tx_done,
    output logic                     frame_busy,
    output logic                     frame_done,
    output logic [7:0]               seq_num
);

    localparam int         NBYTES   = PAYLOAD_WIDTH / 8 + 4;
    localparam logic [5:0] LAST_IDX = 6'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t                   state_r, state_s;
    logic [PAYLOAD_WIDTH-1:0] shift_r, shift_s;
    logic [7:0]               check_r, check_s;
    logic [5:0]               idx_r, idx_s;
    logic [7:0]               din_r, din_s;
    logic [7:0]               seq_r, seq_s;
    logic                     rd_en_s;
    logic                     start_s;
    logic                     done_s;

    // Folds one covered byte (sequence number or payload) into the running check value.
    function automatic logic [7:0] check_update(input logic [7:0] acc, input logic [7:0] data);
        logic [7:0] crc;
`ifdef TELEM_CRC8_EN
        crc = acc ^ data;
        for (int b = 0; b < 8; b++) begin
            if (crc[7]) begin
                crc = {crc[6:0], 1'b0} ^ 8'h07;
            end else begin
                crc = {crc[6:0], 1'b0};
            end
        end
`else
        crc = acc ^ data;
`endif
        return crc;
    endfunction

    // Next-state, datapath and strobe decode for the frame sequencer.
    always_comb begin
        state_s = state_r;
        shift_s = shift_r;
        check_s = check_r;
        idx_s   = idx_r;
        din_s   = din_r;
        seq_s   = seq_r;
        rd_en_s = 1'b0;
        start_s = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (fsm_en && !fifo_empty) begin
                    rd_en_s = 1'b1;
                    shift_s = fifo_rd_data;
                    check_s = 8'h00;
                    idx_s   = 6'd0;
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                state_s = START;
                if (idx_r == 6'd0) begin
                    din_s = SYNC_BYTE0;
                end else if (idx_r == 6'd1) begin
                    din_s = SYNC_BYTE1;
                end else if (idx_r == 6'd2) begin
                    din_s   = seq_r;
                    check_s = check_update(check_r, seq_r);
                end else if (idx_r == LAST_IDX) begin
                    din_s = check_r;
                end else begin
                    // Payload leaves MSB byte first; the register shifts up behind it.
                    din_s   = shift_r[PAYLOAD_WIDTH-1 -: 8];
                    check_s = check_update(check_r, shift_r[PAYLOAD_WIDTH-1 -: 8]);
                    shift_s = shift_r << 8;
                end
            end
            START: begin
                start_s = 1'b1;
                state_s = WAIT;
            end
            WAIT: begin
                if (uart_tx_done) begin
                    if (idx_r < LAST_IDX) begin
                        idx_s   = idx_r + 6'd1;
                        state_s = LOAD;
                    end else begin
                        done_s  = 1'b1;
                        seq_s   = seq_r + 8'd1;
                        state_s = IDLE;
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            shift_r <= '0;
            check_r <= 8'h00;
            idx_r   <= 6'd0;
            din_r   <= 8'h00;
            seq_r   <= 8'h00;
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            check_r <= check_s;
            idx_r   <= idx_s;
            din_r   <= din_s;
            seq_r   <= seq_s;
        end
    end

    assign fifo_rd_en    = rd_en_s;
    assign uart_start_tx = start_s;
    assign uart_tx_din   = din_r;
    assign frame_busy    = (state_r != IDLE);
    assign frame_done    = done_s;
    assign seq_num       = seq_r;

endmodule

// File: tb/tb_telemetry_frame_tx.sv
// Directed bench for telemetry_frame_tx with a 16-bit payload, a FIFO model and a uart_tx model
// that answers each start pulse with a done pulse five cycles later.
module tb_telemetry_frame_tx;

    logic        clk;
    logic        reset;
    logic        fsm_en;
    logic [15:0] fifo_rd_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        uart_start_tx;
    logic [7:0]  uart_tx_din;
    logic        uart_tx_done;
    logic        frame_busy;
    logic        frame_done;
    logic [7:0]  seq_num;

    logic        done_m = 1'b0;
    logic        done_x = 1'b0;
    logic        pop_flag = 1'b0;

    logic [15:0] mem [0:511];
    int          head = 0;
    int          tail = 0;

    int          cyc = 0;
    int          cnt = 0;
    int          sc = 0;
    int          mc = 0;
    int          din_err = 0;
    int          overlap = 0;
    logic [7:0]  last_byte = 8'h00;
    logic [7:0]  bytes_q [$];
    int          st_cyc [$];
    int          md_cyc [$];

    int          pop_count = 0;
    int          fd_count = 0;
    int          rd_empty_viol = 0;
    int          pop_cyc [$];
    int          fd_cyc [$];
    logic [15:0] pop_word [$];

    int          n_checks = 0;
    int          n_errors = 0;

    telemetry_frame_tx #(
        .PAYLOAD_WIDTH (16),
        .SYNC_BYTE0    (8'hA5),
        .SYNC_BYTE1    (8'h5A)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fsm_en        (fsm_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .uart_start_tx (uart_start_tx),
        .uart_tx_din   (uart_tx_din),
        .uart_tx_done  (uart_tx_done),
        .frame_busy    (frame_busy),
        .frame_done    (frame_done),
        .seq_num       (seq_num)
    );

    assign fifo_rd_data = mem[head[8:0]];
    assign fifo_empty   = (head == tail);
    assign uart_tx_done = done_m | done_x;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // uart_tx model and FIFO pop, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        done_m = 1'b0;
        if (reset) begin
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    done_m = 1'b1;
                    mc = mc + 1;
                    md_cyc.push_back(cyc);
                    if (uart_tx_din !== last_byte) din_err = din_err + 1;
                end
            end
            if (uart_start_tx) begin
                if (cnt > 0) overlap = overlap + 1;
                cnt = 5;
                last_byte = uart_tx_din;
                bytes_q.push_back(uart_tx_din);
                sc = sc + 1;
                st_cyc.push_back(cyc);
            end
        end
        if (pop_flag) head = head + 1;
    end

    // Mid-cycle monitor for pops and frame completions.
    always @(negedge clk) begin
        #1;
        pop_flag = fifo_rd_en;
        if (fifo_rd_en) begin
            pop_count = pop_count + 1;
            pop_cyc.push_back(cyc);
            pop_word.push_back(fifo_rd_data);
            if (fifo_empty) rd_empty_viol = rd_empty_viol + 1;
        end
        if (frame_done) begin
            fd_count = fd_count + 1;
            fd_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc_ref(input logic [7:0] acc, input logic [7:0] data);
        logic [7:0] c;
        c = acc ^ data;
        for (int k = 0; k < 8; k++) begin
            if (c[7]) c = (c << 1) ^ 8'h07;
            else      c = c << 1;
        end
        return c;
    endfunction

    function automatic logic [7:0] ref_check(input logic [7:0] seq, input logic [15:0] w);
`ifdef TELEM_CRC8_EN
        return crc_ref(crc_ref(crc_ref(8'h00, seq), w[15:8]), w[7:0]);
`else
        return seq ^ w[15:8] ^ w[7:0];
`endif
    endfunction

    function automatic logic [7:0] exp_byte(input int i, input logic [7:0] seq, input logic [15:0] w);
        case (i)
            0:       return 8'hA5;
            1:       return 8'h5A;
            2:       return seq;
            3:       return w[15:8];
            4:       return w[7:0];
            default: return ref_check(seq, w);
        endcase
    endfunction

    task automatic check_frame(input string tag, input int base, input logic [7:0] seq, input logic [15:0] w);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("%s_b%0d", tag, i), 32'(bytes_q[base + i]), 32'(exp_byte(i, seq, w)));
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        mem[tail[8:0]] = w;
        tail = tail + 1;
    endtask

    task automatic wait_fd(input string tag, input int target, input int limit);
        int n;
        n = 0;
        while (fd_count < target && n < limit) begin
            @(negedge clk);
            n = n + 1;
        end
        check_eq(tag, 32'(fd_count >= target), 32'd1);
    endtask

    initial begin
        int base;
        int p0;
        int f0;
        int s0;
        int m0;
        int n;

        reset = 1'b1;
        fsm_en = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check_eq("rst_start", 32'(uart_start_tx), 32'd0);
        check_eq("rst_din", 32'(uart_tx_din), 32'd0);
        check_eq("rst_busy", 32'(frame_busy), 32'd0);
        check_eq("rst_fdone", 32'(frame_done), 32'd0);
        check_eq("rst_seq", 32'(seq_num), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single frame with payload 0x1234 and sequence 0.
        base = bytes_q.size(); p0 = pop_count; s0 = sc; m0 = mc;
        push_word(16'h1234);
        fsm_en = 1'b1;
        wait_fd("t1_timeout", 1, 200);
        fsm_en = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("t1_len", 32'(bytes_q.size() - base), 32'd6);
        check_frame("t1", base, 8'h00, 16'h1234);
        check_eq("t1_pops", 32'(pop_count - p0), 32'd1);
        check_eq("t1_fdone", 32'(fd_count), 32'd1);
        check_eq("t1_seq", 32'(seq_num), 32'd1);
        check_eq("t1_pop2start", 32'(st_cyc[s0] - pop_cyc[p0]), 32'd2);
        check_eq("t1_done2start", 32'(st_cyc[s0 + 1] - md_cyc[m0]), 32'd2);

        // Three queued words go out back to back.
        base = bytes_q.size(); p0 = pop_count; f0 = fd_cyc.size();
        push_word(16'hA1B2);
        push_word(16'h0F0F);
        push_word(16'hFFFF);
        fsm_en = 1'b1;
        wait_fd("t3_timeout", f0 + 3, 600);
        fsm_en = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("t3_len", 32'(bytes_q.size() - base), 32'd18);
        check_frame("t3f0", base, 8'h01, 16'hA1B2);
        check_frame("t3f1", base + 6, 8'h02, 16'h0F0F);
        check_frame("t3f2", base + 12, 8'h03, 16'hFFFF);
        check_eq("t3_gap1", 32'(pop_cyc[p0 + 1] - fd_cyc[f0]), 32'd1);
        check_eq("t3_gap2", 32'(pop_cyc[p0 + 2] - fd_cyc[f0 + 1]), 32'd1);
        check_eq("t3_seq", 32'(seq_num), 32'd4);

        // fsm_en drops after the second byte: frame completes, no further pop.
        base = bytes_q.size(); p0 = pop_count; m0 = mc; f0 = fd_count;
        push_word(16'h7E81);
        push_word(16'h3C3C);
        fsm_en = 1'b1;
        n = 0;
        while (mc < m0 + 2 && n < 200) begin
            @(negedge clk);
            n = n + 1;
        end
        fsm_en = 1'b0;
        check_eq("t4_two_done", 32'(mc - m0), 32'd2);
        wait_fd("t4_timeout", f0 + 1, 200);
        repeat (20) @(negedge clk);
        check_eq("t4_len", 32'(bytes_q.size() - base), 32'd6);
        check_frame("t4", base, 8'h04, 16'h7E81);
        check_eq("t4_pops", 32'(pop_count - p0), 32'd1);
        check_eq("t4_left", 32'(tail - head), 32'd1);

        // Reset while waiting on the payload's first byte.
        s0 = sc;
        fsm_en = 1'b1;
        n = 0;
        while (sc < s0 + 4 && n < 200) begin
            @(negedge clk);
            n = n + 1;
        end
        check_eq("t5_reach", 32'(sc - s0), 32'd4);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        fsm_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check_eq("t5_rd_en", 32'(fifo_rd_en), 32'd0);
        check_eq("t5_start", 32'(uart_start_tx), 32'd0);
        check_eq("t5_din", 32'(uart_tx_din), 32'd0);
        check_eq("t5_busy", 32'(frame_busy), 32'd0);
        check_eq("t5_fdone", 32'(frame_done), 32'd0);
        check_eq("t5_seq", 32'(seq_num), 32'd0);
        s0 = sc;
        done_x = 1'b1;
        @(negedge clk);
        done_x = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("t5_spurious", 32'(sc - s0), 32'd0);
        base = bytes_q.size(); f0 = fd_count;
        push_word(16'hC3E1);
        fsm_en = 1'b1;
        wait_fd("t5_timeout", f0 + 1, 200);
        fsm_en = 1'b0;
        repeat (10) @(negedge clk);
        check_frame("t5", base, 8'h00, 16'hC3E1);

        // Run the sequence number up to 0xFF, then across the wrap.
        for (int i = 0; i < 300; i++) push_word(16'(i * 257) ^ 16'h5A3C);
        fsm_en = 1'b1;
        n = 0;
        while (seq_num !== 8'hFF && n < 20000) begin
            @(negedge clk);
            n = n + 1;
        end
        check_eq("t6_reach_ff", 32'(seq_num), 32'hFF);
        base = bytes_q.size();
        wait_fd("t6_timeout", fd_count + 1, 200);
        fsm_en = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("t6_len", 32'(bytes_q.size() - base), 32'd6);
        check_frame("t6", base, 8'hFF, pop_word[$]);
        check_eq("t6_wrap", 32'(seq_num), 32'd0);

        check_eq("rd_when_empty", 32'(rd_empty_viol), 32'd0);
        check_eq("byte_overlap", 32'(overlap), 32'd0);
        check_eq("din_stable", 32'(din_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
